// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped read-only cache.
// Block words are packed little-end first: word i sits at bits [32*i +: 32].
package cache_pkg;

  localparam int ADDR_W          = 15;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    MEM_REQ,
    MEM_WAIT,
    RESPOND
  } state_t;

  function automatic logic [WORD_W-1:0] block_word(
    input logic [BLOCK_W-1:0] blk,
    input logic [1:0]         off
  );
    return blk[WORD_W*int'(off) +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays with a registered read port and a fill port.
// Valid bits clear on reset or flush; tag and data arrays are plain RAM.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = ADDR_W - 2 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_W-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0]    wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [BLOCK_W-1:0]  data [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (flush) begin
        valid <= '0;
      end else if (wr_en) begin
        valid[wr_index] <= 1'b1;
      end
      if (rd_en) begin
        rd_valid <= valid[rd_index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tags[rd_index];
      rd_data <= data[rd_index];
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache controller: 4-word lines, block fill on miss,
// out-of-range rejection and hit/access counters.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 10,
  parameter int MEM_LIMIT  = 32000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_data,
  output logic               resp_hit,
  output logic               resp_err,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_valid,
  input  logic [BLOCK_W-1:0] mem_data,
  input  logic               flush,
  output logic [31:0]        hit_count,
  output logic [31:0]        access_count
);

  localparam int TAG_BITS = ADDR_W - 2 - INDEX_BITS;
  localparam int TAG_LO   = INDEX_BITS + 2;

  state_t state, state_nx;

  logic [ADDR_W-1:0]   addr;
  logic [BLOCK_W-1:0]  blk;
  logic                hit_q;
  logic                err_q;
  logic                accept;
  logic                in_range;
  logic                tag_hit;
  logic                fill;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [BLOCK_W-1:0]  rd_data;

  // req_ready is held low while reset is asserted
  assign req_ready = rst & (state == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign fill      = (state == MEM_WAIT) & mem_valid;
  assign in_range  = addr < ADDR_W'(MEM_LIMIT);
  assign tag_hit   = rd_valid & (rd_tag == addr[ADDR_W-1:TAG_LO]);

  cache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .flush    ((state == IDLE) & flush),
    .rd_en    (accept),
    .rd_index (req_addr[TAG_LO-1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_index (addr[TAG_LO-1:2]),
    .wr_tag   (addr[ADDR_W-1:TAG_LO]),
    .wr_data  (mem_data)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = COMPARE;
      COMPARE:  state_nx = (!in_range || tag_hit) ? RESPOND : MEM_REQ;
      MEM_REQ:  state_nx = MEM_WAIT;
      MEM_WAIT: if (mem_valid) state_nx = RESPOND;
      RESPOND:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr         <= '0;
      blk          <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr <= req_addr;
      end
      if (state == COMPARE) begin
        err_q <= !in_range;
        hit_q <= in_range & tag_hit;
        blk   <= rd_data;
        if (in_range) begin
          access_count <= access_count + 32'd1;
        end
        if (in_range && tag_hit) begin
          hit_count <= hit_count + 32'd1;
        end
      end
      if (fill) begin
        blk <= mem_data;
      end
    end
  end

  assign resp_valid = (state == RESPOND);
  assign resp_hit   = resp_valid & hit_q;
  assign resp_err   = resp_valid & err_q;
  assign resp_data  = (resp_valid && !err_q) ? block_word(blk, addr[1:0])
                                             : '0;
  assign mem_req    = (state == MEM_REQ);
  assign mem_addr   = {addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomized bench for dm_cache_ctrl against a tag/valid map model,
// with directed cold-miss, hit, conflict, range, flush and reset cases.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [14:0]  req_addr;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         resp_hit;
  logic         resp_err;
  logic         mem_req;
  logic [14:0]  mem_addr;
  logic         mem_valid;
  logic [127:0] mem_data;
  logic         flush;
  logic [31:0]  hit_count;
  logic [31:0]  access_count;

  dm_cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_hit     (resp_hit),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .flush        (flush),
    .hit_count    (hit_count),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        h;
    logic        e;
    logic [31:0] hc;
    logic [31:0] ac;
  } exp_t;

  exp_t        q[$];
  bit          mv[1024];
  logic [2:0]  mt[1024];
  int unsigned mhc;
  int unsigned mac;
  bit          busy;
  int          tests;
  int          fails;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Main memory contents; block 0x0004 carries the hand-picked words.
  function automatic logic [31:0] mem_word(input logic [14:0] a);
    if (a[14:2] == 13'd1)
      return 32'h11 * (32'(a[1:0]) + 32'd1);
    return (32'(a) * 32'h9E3779B1) + 32'h1234;
  endfunction

  function automatic logic [127:0] mem_block(input logic [14:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++)
      b[32*i +: 32] = mem_word({a[14:2], 2'(i)});
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mv[i] = 0;
  endtask

  // Compare process: every cycle, ready and idle outputs; responses vs model.
  always @(negedge clk) begin
    chk("req_ready", req_ready, rst && !busy && !flush);
    if (resp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", resp_data, e.d);
        chk("resp_hit", resp_hit, e.h);
        chk("resp_err", resp_err, e.e);
        chk("hit_count", hit_count, e.hc);
        chk("access_count", access_count, e.ac);
      end
      busy = 0;
    end else begin
      chk("idle_flags", {resp_hit, resp_err}, 0);
    end
  end

  task automatic do_read(input logic [14:0] a, output logic [31:0] d,
                         output logic h, output logic er,
                         output logic got_m, output logic [14:0] maddr);
    exp_t e;
    logic miss;
    int   n;
    bit   done;
    int   dly;
    @(posedge clk); #1;
    req_valid = 1; req_addr = a;
    @(posedge clk); #1;
    req_valid = 0; busy = 1;
    miss = 0; e.d = 0; e.h = 0; e.e = 0;
    if (a >= 15'd32000) begin
      e.e = 1;
    end else begin
      mac++;
      e.d = mem_word(a);
      if (mv[a[11:2]] && mt[a[11:2]] == a[14:12]) begin
        e.h = 1; mhc++;
      end else begin
        miss = 1; mv[a[11:2]] = 1; mt[a[11:2]] = a[14:12];
      end
    end
    e.hc = mhc; e.ac = mac;
    q.push_back(e);
    got_m = 0; maddr = 0; done = 0; n = 0; d = 0; h = 0; er = 0;
    while (!done && n < 100) begin
      @(negedge clk); n++;
      if (mem_req) begin
        got_m = 1; maddr = mem_addr;
        chk("mreq_lat", n, 2);
        chk("mem_addr", mem_addr, {a[14:2], 2'b00});
        dly = $urandom_range(0, 4);
        @(posedge clk); #1;
        chk("mreq_pulse", mem_req, 0);
        repeat (dly) @(posedge clk);
        #1 mem_valid = 1; mem_data = mem_block(a);
        @(posedge clk); #1;
        mem_valid = 0; mem_data = {4{$urandom}};
        @(negedge clk);
        chk("miss_resp_lat", resp_valid, 1);
        done = 1; d = resp_data; h = resp_hit; er = resp_err;
      end else if (resp_valid) begin
        chk("hit_lat", n, 2);
        done = 1; d = resp_data; h = resp_hit; er = resp_err;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout: addr %h got no response expected one", a);
    end
    chk("miss_vs_mreq", got_m, miss);
  endtask

  task automatic do_flush();
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    model_clear();
  endtask

  task automatic reset_mid(input bit in_wait);
    int n;
    do_flush();
    @(posedge clk); #1 req_valid = 1; req_addr = 15'h0005;
    @(posedge clk); #1 req_valid = 0; busy = 1;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    chk("rst_mreq_seen", mem_req, 1);
    if (in_wait) @(negedge clk);
    #2 rst = 0; busy = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    model_clear(); mhc = 0; mac = 0;
    @(posedge clk); #1;
    chk("rst_hc", hit_count, 0);
    chk("rst_ac", access_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    @(posedge clk); #1 mem_valid = 1; mem_data = mem_block(15'h0005);
    @(posedge clk); #1 mem_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] d;
  logic        h, er, gm;
  logic [14:0] ma;

  initial begin
    tests = 0; fails = 0; busy = 0; mhc = 0; mac = 0;
    model_clear();
    rst = 0; req_valid = 0; req_addr = 0; mem_valid = 0;
    mem_data = 0; flush = 0;
    #13;
    chk("reset_ready", req_ready, 0);
    chk("reset_resp", resp_valid, 0);
    chk("reset_mreq", mem_req, 0);
    chk("reset_hc", hit_count, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);
    chk("post_reset_ac", access_count, 0);

    do_read(15'h0005, d, h, er, gm, ma);
    chk("cold_data", d, 32'h22);
    chk("cold_hit", h, 0);
    chk("cold_maddr", ma, 15'h0004);
    chk("cold_ac", access_count, 1);
    chk("cold_hc", hit_count, 0);

    do_read(15'h0006, d, h, er, gm, ma);
    chk("hit_data", d, 32'h33);
    chk("hit_hit", h, 1);
    chk("hit_nomreq", gm, 0);
    chk("hit_hc", hit_count, 1);

    do_read(15'h1004, d, h, er, gm, ma);
    chk("conf_hit", h, 0);
    chk("conf_maddr", ma, 15'h1004);
    do_read(15'h0004, d, h, er, gm, ma);
    chk("reread_hit", h, 0);
    chk("reread_data", d, 32'h11);
    chk("reread_maddr", ma, 15'h0004);
    chk("conf_ac", access_count, 4);
    chk("conf_hc", hit_count, 1);

    do_read(15'd32000, d, h, er, gm, ma);
    chk("range_err", er, 1);
    chk("range_data", d, 0);
    chk("range_nomreq", gm, 0);
    chk("range_ac", access_count, 4);
    chk("range_hc", hit_count, 1);
    do_read(15'd31999, d, h, er, gm, ma);
    chk("edge_err", er, 0);
    chk("edge_maddr", ma, 15'h7CFC);

    @(posedge clk); #1 flush = 1; req_valid = 1; req_addr = 15'h0005;
    @(negedge clk);
    chk("flush_ready", req_ready, 0);
    @(posedge clk); #1 flush = 0; req_valid = 0;
    model_clear();
    do_read(15'h0005, d, h, er, gm, ma);
    chk("flush_miss", gm, 1);
    chk("flush_ac", access_count, 6);
    chk("flush_hc", hit_count, 1);

    reset_mid(1'b0);
    reset_mid(1'b1);
    do_read(15'h0005, d, h, er, gm, ma);
    chk("post_rst_miss", gm, 1);
    chk("post_rst_ac", access_count, 1);

    for (int i = 0; i < 250; i++) begin
      int unsigned r;
      logic [14:0] a;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        do_flush();
      end else begin
        if (r < 15) begin
          a = 15'($urandom_range(31990, 32767));
        end else begin
          a[14:12] = 3'($urandom_range(0, 3));
          a[11:2]  = 10'($urandom_range(0, 3));
          a[1:0]   = 2'($urandom_range(0, 3));
        end
        do_read(a, d, h, er, gm, ma);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
